turtle_io_responder: RTL

TURTLE_IO_RESPONDER -- requirements
Module: turtle_io_responder

---
 rtl/turtle_io_responder.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/turtle_io_responder.sv
// Memory-mapped I/O block: GPIO, synchronized GPIO input, UART transmitter with TX FIFO.
// Define TURTLE_IO_TIMER_EN to add the 16-bit free-running timer at offsets 0x5/0x6.
module turtle_io_responder #(
    parameter int                  D_ADDR_W       = 12,
    parameter logic [D_ADDR_W-1:0] IO_BASE        = 12'hF00,
    parameter int                  FIFO_DEPTH     = 4,
    parameter logic [7:0]          BAUD_DIV_RESET = 8'd103
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [D_ADDR_W-1:0] data_addr,
    input  logic                write_enable,
    input  logic [7:0]          write_data,
    output logic [7:0]          read_data,
    output logic                int_mem_select,
    output logic [7:0]          gpio_out,
    input  logic [7:0]          gpio_in,
    output logic                uart_tx
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    localparam logic [3:0] OFF_GPIO_OUT = 4'h0;
    localparam logic [3:0] OFF_GPIO_IN  = 4'h1;
    localparam logic [3:0] OFF_STATUS   = 4'h3;
    localparam logic [3:0] OFF_UART_TX  = 4'h2;
    localparam logic [3:0] OFF_BAUD_DIV = 4'h4;
`ifdef TURTLE_IO_TIMER_EN
    localparam logic [3:0] OFF_TIMER_LO = 4'h5;
    localparam logic [3:0] OFF_TIMER_HI = 4'h6;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    tx_state_t        tx_state, tx_state_next;
    logic [3:0]       offset;
    logic             io_wr;
    logic [7:0]       gpio_sync1, gpio_sync2;
    logic [7:0]       baud_div;
    logic             overflow;
    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             fifo_full, fifo_empty;
    logic             push_req, push_ok, pop;
    logic [7:0]       baud_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             bit_end;
    logic             tx_busy;
    logic [7:0]       status;

    assign int_mem_select = (data_addr[D_ADDR_W-1:4] != IO_BASE[D_ADDR_W-1:4]);
    assign offset         = data_addr[3:0];
    assign io_wr          = write_enable && !int_mem_select;

    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign push_req   = io_wr && (offset == OFF_UART_TX);
    // A full FIFO still takes the byte when the transmitter frees a slot this same cycle.
    assign push_ok    = push_req && (!fifo_full || pop);

    assign bit_end = (baud_cnt == 8'd0);
    assign tx_busy = (tx_state != IDLE);
    assign status  = {overflow, 4'(count), fifo_empty, fifo_full, tx_busy};

    always_ff @(posedge clk) begin
        if (reset) begin
            gpio_out   <= 8'h00;
            baud_div   <= BAUD_DIV_RESET;
            overflow   <= 1'b0;
            gpio_sync1 <= 8'h00;
            gpio_sync2 <= 8'h00;
        end else begin
            gpio_sync1 <= gpio_in;
            gpio_sync2 <= gpio_sync1;
            if (io_wr && offset == OFF_GPIO_OUT) gpio_out <= write_data;
            if (io_wr && offset == OFF_BAUD_DIV) baud_div <= write_data;
            if (push_req && !push_ok) overflow <= 1'b1;
            else if (io_wr && offset == OFF_STATUS && write_data[7]) overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= write_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) tx_state <= IDLE;
        else       tx_state <= tx_state_next;
    end

    always_comb begin
        tx_state_next = tx_state;
        pop           = 1'b0;
        case (tx_state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop           = 1'b1;
                    tx_state_next = START;
                end
            end
            START: if (bit_end) tx_state_next = DATA;
            DATA:  if (bit_end && bit_idx == 3'd7) tx_state_next = STOP;
            STOP: begin
                if (bit_end) begin
                    if (!fifo_empty) begin
                        pop           = 1'b1;
                        tx_state_next = START;
                    end else begin
                        tx_state_next = IDLE;
                    end
                end
            end
            default: tx_state_next = IDLE;
        endcase
    end

    // baud_cnt is reloaded from baud_div at every bit start, so a divider write lands on the next bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            baud_cnt  <= 8'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'hFF;
        end else if (pop) begin
            shift_reg <= fifo_mem[rd_ptr];
            baud_cnt  <= baud_div;
            bit_idx   <= 3'd0;
        end else if (tx_state != IDLE) begin
            if (bit_end) begin
                baud_cnt <= baud_div;
                if (tx_state == DATA) begin
                    shift_reg <= shift_reg >> 1;
                    bit_idx   <= bit_idx + 3'd1;
                end
            end else begin
                baud_cnt <= baud_cnt - 8'd1;
            end
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        case (tx_state)
            START:   uart_tx = 1'b0;
            DATA:    uart_tx = shift_reg[0];
            default: uart_tx = 1'b1;
        endcase
    end

`ifdef TURTLE_IO_TIMER_EN
    logic [15:0] timer;
    logic [7:0]  timer_shadow;
    logic        timer_wr;

    assign timer_wr = io_wr && (offset == OFF_TIMER_LO || offset == OFF_TIMER_HI);

    // Addressing TIMER_LO captures the high byte so a following TIMER_HI read is coherent.
    always_ff @(posedge clk) begin
        if (reset || timer_wr) begin
            timer        <= 16'h0000;
            timer_shadow <= 8'h00;
        end else begin
            timer <= timer + 16'd1;
            if (!int_mem_select && offset == OFF_TIMER_LO) timer_shadow <= timer[15:8];
        end
    end
`endif

    always_comb begin
        read_data = 8'h00;
        if (!int_mem_select) begin
            case (offset)
                OFF_GPIO_OUT: read_data = gpio_out;
                OFF_GPIO_IN:  read_data = gpio_sync2;
                OFF_STATUS:   read_data = status;
                OFF_BAUD_DIV: read_data = baud_div;
`ifdef TURTLE_IO_TIMER_EN
                OFF_TIMER_LO: read_data = timer[7:0];
                OFF_TIMER_HI: read_data = timer_shadow;
`endif
                default:      read_data = 8'h00;
            endcase
        end
    end

endmodule
